qkv_stream_issuer: RTL and testbench

- Producer side of the Q/K/V valid/ready streams feeding the attention dot-product stage.
- Fetches Q rows from the Q buffer SRAM and K/V rows from the K/V buffer SRAMs, all with 1-cycle read latency.
- Per query row: issues the Q vector exactly once, then SEQ_LEN K vectors and SEQ_LEN V vectors, in key order.
- Matches the consumer, which holds each Q for SEQ_LEN K/V pairs before accepting the next Q.

---
 rtl/qkv_stream_issuer_pkg.sv | 16 +
 rtl/sys_defs_pkg.sv | 14 +
 rtl/qkv_stream_issuer_if.sv | 43 ++++
 rtl/qkv_stream_issuer_stream_fetch_channel.sv | 95 +++++++++
 rtl/qkv_stream_issuer.sv | 71 +++++++
 tb/tb_qkv_stream_issuer.sv | 231 +++++++++++++++++++++++
 6 files changed

// File: rtl/qkv_stream_issuer_pkg.sv
// Local definitions for the Q/K/V stream issuer: FSM states, FIFO depth and
// an address-width helper that stays legal for single-row memories.
package qkv_stream_issuer_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int FIFO_DEPTH = 2;

    // $clog2(1) is 0, which would make a zero-width address port.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/sys_defs_pkg.sv
// Shared datapath definitions for the attention block: vector payload types
// and the sequence-length ceiling used as the default row count.
`ifndef MAX_SEQ_LENGTH
`define MAX_SEQ_LENGTH 8
`endif

package sys_defs_pkg;
    localparam int VEC_LEN = 4;
    localparam int ELEM_W  = 16;

    typedef logic [VEC_LEN-1:0][ELEM_W-1:0] Q_VECTOR_T;
    typedef logic [VEC_LEN-1:0][ELEM_W-1:0] K_VECTOR_T;
    typedef logic [VEC_LEN-1:0][ELEM_W-1:0] V_VECTOR_T;
endpackage

// File: rtl/qkv_stream_issuer_if.sv
// SRAM read ports and Q/K/V valid/ready streams of the issuer. The issuer
// side is the master; SRAMs and the dot-product consumer sit on the slave side.
interface qkv_stream_issuer_if #(
    parameter int SEQ_LEN    = `MAX_SEQ_LENGTH,
    parameter int NUM_Q_ROWS = `MAX_SEQ_LENGTH
);
    import sys_defs_pkg::*;
    import qkv_stream_issuer_pkg::*;

    localparam int QAW = addr_w(NUM_Q_ROWS);
    localparam int KAW = addr_w(SEQ_LEN);

    logic           q_mem_ren, k_mem_ren, v_mem_ren;
    logic [QAW-1:0] q_mem_addr;
    logic [KAW-1:0] k_mem_addr, v_mem_addr;
    Q_VECTOR_T      q_mem_rdata;
    K_VECTOR_T      k_mem_rdata;
    V_VECTOR_T      v_mem_rdata;

    logic           Q_vld_out, K_vld_out, V_vld_out;
    logic           Q_rdy_in, K_rdy_in, V_rdy_in;
    Q_VECTOR_T      q_out;
    K_VECTOR_T      k_out;
    V_VECTOR_T      v_out;

    modport master (
        output q_mem_ren, k_mem_ren, v_mem_ren,
        output q_mem_addr, k_mem_addr, v_mem_addr,
        input  q_mem_rdata, k_mem_rdata, v_mem_rdata,
        output Q_vld_out, K_vld_out, V_vld_out,
        input  Q_rdy_in, K_rdy_in, V_rdy_in,
        output q_out, k_out, v_out
    );

    modport slave (
        input  q_mem_ren, k_mem_ren, v_mem_ren,
        input  q_mem_addr, k_mem_addr, v_mem_addr,
        output q_mem_rdata, k_mem_rdata, v_mem_rdata,
        input  Q_vld_out, K_vld_out, V_vld_out,
        output Q_rdy_in, K_rdy_in, V_rdy_in,
        input  q_out, k_out, v_out
    );
endinterface

// File: rtl/qkv_stream_issuer_stream_fetch_channel.sv
// One fetch channel: reads TOTAL rows from a 1-cycle-latency SRAM (address
// wrapping at ADDR_MOD), buffers them in a 2-entry FIFO and presents them on
// a valid/ready stream.
module stream_fetch_channel
    import qkv_stream_issuer_pkg::*;
#(
    parameter type T        = logic [31:0],
    parameter int  TOTAL    = 1,
    parameter int  ADDR_MOD = 1,
    parameter int  AW       = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          run_i,
    output logic          ren_o,
    output logic [AW-1:0] addr_o,
    input  T              rdata_i,
    output logic          vld_o,
    input  logic          rdy_i,
    output T              data_o,
    output logic          last_accepted_o
);
    localparam int CW = $clog2(TOTAL + 1);

    T              fifo_q [FIFO_DEPTH];
    logic          wr_ptr_q, rd_ptr_q;
    logic [1:0]    count_q, count_d;
    logic          inflight_q;
    logic [CW-1:0] issued_q, issued_d;
    logic [CW-1:0] accepted_q, accepted_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          push, pop;

    // Read data lands one cycle after ren; the in-flight flag marks it.
    assign push            = inflight_q;
    assign pop             = vld_o && rdy_i;
    assign vld_o           = (count_q != 2'd0);
    assign data_o          = fifo_q[rd_ptr_q];
    assign addr_o          = addr_q;
    assign last_accepted_o = (accepted_q == CW'(TOTAL));

    // Issue while a FIFO slot is guaranteed; a pop this cycle frees one,
    // which is what lets the channel stream back-to-back at 1 item/cycle.
    always_comb begin
        ren_o = run_i
             && ((int'(count_q) + int'(inflight_q) - int'(pop)) < FIFO_DEPTH)
             && (issued_q < CW'(TOTAL));
    end

    // Next-state for counters and the wrapping read address.
    always_comb begin
        count_d    = count_q + 2'(push) - 2'(pop);
        issued_d   = issued_q;
        accepted_d = accepted_q;
        addr_d     = addr_q;
        if (clr_i) begin
            issued_d   = '0;
            accepted_d = '0;
            addr_d     = '0;
        end else begin
            if (ren_o) begin
                issued_d = issued_q + 1'b1;
                addr_d   = (addr_q == AW'(ADDR_MOD - 1)) ? '0 : addr_q + 1'b1;
            end
            if (pop) accepted_d = accepted_q + 1'b1;
        end
    end

    // Control state; reset drops in-flight reads so late rdata is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            inflight_q <= 1'b0;
            issued_q   <= '0;
            accepted_q <= '0;
            addr_q     <= '0;
        end else begin
            count_q    <= count_d;
            inflight_q <= ren_o;
            issued_q   <= issued_d;
            accepted_q <= accepted_d;
            addr_q     <= addr_d;
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
        end
    end

    // FIFO storage; contents are meaningless while count is zero.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= rdata_i;
    end
endmodule

// File: rtl/qkv_stream_issuer.sv
// Issues one Q row then SEQ_LEN K and V rows per query row to the attention
// dot-product stage. The top only sequences the job; each stream is an
// independent fetch channel.
module qkv_stream_issuer
    import sys_defs_pkg::*;
    import qkv_stream_issuer_pkg::*;
#(
    parameter int SEQ_LEN    = `MAX_SEQ_LENGTH,
    parameter int NUM_Q_ROWS = `MAX_SEQ_LENGTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    qkv_stream_issuer_if.master bus
);
    localparam int QAW    = addr_w(NUM_Q_ROWS);
    localparam int KAW    = addr_w(SEQ_LEN);
    localparam int KV_TOT = NUM_Q_ROWS * SEQ_LEN;

    state_e state_q, state_d;
    logic   run, clr;
    logic   q_last, k_last, v_last;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state: start only counts in IDLE; finish when every channel drained.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (q_last && k_last && v_last) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: clr rewinds the channels on the accepting start edge.
    always_comb begin
        run  = (state_q == ST_RUN);
        clr  = (state_q == ST_IDLE) && start;
        busy = (state_q == ST_RUN) || (state_q == ST_DONE);
        done = (state_q == ST_DONE);
    end

    stream_fetch_channel #(.T(Q_VECTOR_T), .TOTAL(NUM_Q_ROWS), .ADDR_MOD(NUM_Q_ROWS), .AW(QAW)) u_q (
        .clk, .rst, .clr_i(clr), .run_i(run),
        .ren_o(bus.q_mem_ren), .addr_o(bus.q_mem_addr), .rdata_i(bus.q_mem_rdata),
        .vld_o(bus.Q_vld_out), .rdy_i(bus.Q_rdy_in), .data_o(bus.q_out),
        .last_accepted_o(q_last)
    );

    stream_fetch_channel #(.T(K_VECTOR_T), .TOTAL(KV_TOT), .ADDR_MOD(SEQ_LEN), .AW(KAW)) u_k (
        .clk, .rst, .clr_i(clr), .run_i(run),
        .ren_o(bus.k_mem_ren), .addr_o(bus.k_mem_addr), .rdata_i(bus.k_mem_rdata),
        .vld_o(bus.K_vld_out), .rdy_i(bus.K_rdy_in), .data_o(bus.k_out),
        .last_accepted_o(k_last)
    );

    stream_fetch_channel #(.T(V_VECTOR_T), .TOTAL(KV_TOT), .ADDR_MOD(SEQ_LEN), .AW(KAW)) u_v (
        .clk, .rst, .clr_i(clr), .run_i(run),
        .ren_o(bus.v_mem_ren), .addr_o(bus.v_mem_addr), .rdata_i(bus.v_mem_rdata),
        .vld_o(bus.V_vld_out), .rdy_i(bus.V_rdy_in), .data_o(bus.v_out),
        .last_accepted_o(v_last)
    );
endmodule

// File: tb/tb_qkv_stream_issuer.sv
// Directed bench for qkv_stream_issuer with SEQ_LEN=4, NUM_Q_ROWS=2.
module tb_qkv_stream_issuer;
    import sys_defs_pkg::*;

    localparam int SL  = 4;
    localparam int NQ  = 2;
    localparam int NKV = NQ * SL;

    typedef struct {
        int mode;      // 0 ready, 1 random, 2 K stall, 3 Q held until 4 K
        bit restart;   // pulse start again while running
        int exp_q;
        int exp_k;
        int exp_v;
        int exp_done;
    } vec_t;

    logic clk = 1'b0;
    logic rst, start, busy, done;

    qkv_stream_issuer_if #(.SEQ_LEN(SL), .NUM_Q_ROWS(NQ)) bus();

    qkv_stream_issuer #(.SEQ_LEN(SL), .NUM_Q_ROWS(NQ)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    Q_VECTOR_T qmem [NQ];
    K_VECTOR_T kmem [SL];
    V_VECTOR_T vmem [SL];
    localparam Q_VECTOR_T STALE = {4{16'hDEAD}};

    // SRAM models, 1-cycle read latency.
    always @(posedge clk) begin
        bus.q_mem_rdata <= bus.q_mem_ren ? qmem[bus.q_mem_addr] : STALE;
        bus.k_mem_rdata <= bus.k_mem_ren ? kmem[bus.k_mem_addr] : STALE;
        bus.v_mem_rdata <= bus.v_mem_ren ? vmem[bus.v_mem_addr] : STALE;
    end

    int n_vec, n_err;
    int q_hs, k_hs, v_hs, q_rd, k_rd, v_rd, done_cnt;
    int mode, stall_cyc, v_at_stall;
    bit m3_checked;
    bit q_hold, k_hold, v_hold;
    Q_VECTOR_T q_prev, k_prev, v_prev;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sb_clear();
        q_hs = 0; k_hs = 0; v_hs = 0;
        q_rd = 0; k_rd = 0; v_rd = 0;
        done_cnt = 0; stall_cyc = 0; v_at_stall = 0; m3_checked = 0;
    endtask

    // Scoreboard step, sampled on the falling edge.
    task automatic mon_step();
        if (!rst && q_hold) begin
            chk("q_hold_vld", 64'(bus.Q_vld_out), 64'(1));
            chk("q_hold_data", 64'(bus.q_out), 64'(q_prev));
        end
        if (!rst && k_hold) begin
            chk("k_hold_vld", 64'(bus.K_vld_out), 64'(1));
            chk("k_hold_data", 64'(bus.k_out), 64'(k_prev));
        end
        if (!rst && v_hold) begin
            chk("v_hold_vld", 64'(bus.V_vld_out), 64'(1));
            chk("v_hold_data", 64'(bus.v_out), 64'(v_prev));
        end
        q_hold = bus.Q_vld_out && !bus.Q_rdy_in && !rst; q_prev = bus.q_out;
        k_hold = bus.K_vld_out && !bus.K_rdy_in && !rst; k_prev = bus.k_out;
        v_hold = bus.V_vld_out && !bus.V_rdy_in && !rst; v_prev = bus.v_out;
        if (rst) return;

        if (bus.Q_vld_out && bus.Q_rdy_in) begin
            chk("q_data", 64'(bus.q_out), 64'(qmem[q_hs % NQ])); q_hs++;
        end
        if (bus.K_vld_out && bus.K_rdy_in) begin
            chk("k_data", 64'(bus.k_out), 64'(kmem[k_hs % SL])); k_hs++;
        end
        if (bus.V_vld_out && bus.V_rdy_in) begin
            chk("v_data", 64'(bus.v_out), 64'(vmem[v_hs % SL])); v_hs++;
        end
        if (bus.q_mem_ren) begin chk("q_addr", 64'(bus.q_mem_addr), 64'(q_rd % NQ)); q_rd++; end
        if (bus.k_mem_ren) begin chk("k_addr", 64'(bus.k_mem_addr), 64'(k_rd % SL)); k_rd++; end
        if (bus.v_mem_ren) begin chk("v_addr", 64'(bus.v_mem_addr), 64'(v_rd % SL)); v_rd++; end
        if (done) done_cnt++;

        // K stall: FIFO full by the 3rd stalled cycle, so no more K reads.
        if (mode == 2 && !bus.K_rdy_in && stall_cyc >= 3) begin
            chk("k_stall_ren", 64'(bus.k_mem_ren), 64'(0));
            chk("k_stall_vld", 64'(bus.K_vld_out), 64'(1));
            if (stall_cyc == 5) chk("v_runs_during_k_stall", 64'(v_hs > v_at_stall), 64'(1));
        end
        // Q held back: both rows fetched and parked, head is row 0.
        if (mode == 3 && !m3_checked && k_hs >= 4) begin
            m3_checked = 1;
            chk("q_park_reads", 64'(q_rd), 64'(2));
            chk("q_park_vld", 64'(bus.Q_vld_out), 64'(1));
            chk("q_park_head", 64'(bus.q_out), 64'(qmem[0]));
            chk("q_park_hs", 64'(q_hs), 64'(0));
        end
    endtask

    // Consumer ready pattern, applied just after each rising edge.
    task automatic rdy_step();
        case (mode)
            1: begin
                bus.Q_rdy_in = 1'($urandom_range(0, 1));
                bus.K_rdy_in = 1'($urandom_range(0, 1));
                bus.V_rdy_in = 1'($urandom_range(0, 1));
            end
            2: begin
                bus.Q_rdy_in = 1'b1; bus.V_rdy_in = 1'b1;
                if (k_hs >= 3 && stall_cyc < 5) begin
                    if (stall_cyc == 0) v_at_stall = v_hs;
                    stall_cyc++;
                    bus.K_rdy_in = 1'b0;
                end else bus.K_rdy_in = 1'b1;
            end
            3: begin
                bus.K_rdy_in = 1'b1; bus.V_rdy_in = 1'b1;
                bus.Q_rdy_in = (k_hs >= 4);
            end
            default: begin
                bus.Q_rdy_in = 1'b1; bus.K_rdy_in = 1'b1; bus.V_rdy_in = 1'b1;
            end
        endcase
    endtask

    task automatic run_job(input vec_t v);
        int cyc;
        sb_clear();
        mode = v.mode;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        if (v.restart) begin
            repeat (3) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        cyc = 0;
        @(negedge clk);
        while (!done && cyc < 500) begin @(negedge clk); cyc++; end
        chk("job_timeout", 64'(done), 64'(1));
        chk("busy_with_done", 64'(busy), 64'(1));
        @(negedge clk);
        chk("busy_after_done", 64'(busy), 64'(0));
        chk("done_one_cycle", 64'(done), 64'(0));
        repeat (4) @(negedge clk);
        chk("q_handshakes", 64'(q_hs), 64'(v.exp_q));
        chk("k_handshakes", 64'(k_hs), 64'(v.exp_k));
        chk("v_handshakes", 64'(v_hs), 64'(v.exp_v));
        chk("q_reads", 64'(q_rd), 64'(v.exp_q));
        chk("k_reads", 64'(k_rd), 64'(v.exp_k));
        chk("v_reads", 64'(v_rd), 64'(v.exp_v));
        chk("done_pulses", 64'(done_cnt), 64'(v.exp_done));
        mode = 0;
    endtask

    initial begin
        vec_t tbl [5];
        int cyc;
        tbl[0] = '{0, 1'b0, NQ, NKV, NKV, 1};
        tbl[1] = '{2, 1'b0, NQ, NKV, NKV, 1};
        tbl[2] = '{1, 1'b0, NQ, NKV, NKV, 1};
        tbl[3] = '{0, 1'b1, NQ, NKV, NKV, 1};
        tbl[4] = '{3, 1'b0, NQ, NKV, NKV, 1};

        for (int i = 0; i < NQ; i++)
            for (int e = 0; e < VEC_LEN; e++) qmem[i][e] = 16'(16'h1000 + i * 16 + e);
        for (int i = 0; i < SL; i++)
            for (int e = 0; e < VEC_LEN; e++) begin
                kmem[i][e] = 16'(16'h2000 + i * 16 + e);
                vmem[i][e] = 16'(16'h3000 + i * 16 + e);
            end

        n_vec = 0; n_err = 0; mode = 0;
        q_hold = 0; k_hold = 0; v_hold = 0;
        sb_clear();
        rst = 1'b1; start = 1'b0;
        bus.Q_rdy_in = 1'b0; bus.K_rdy_in = 1'b0; bus.V_rdy_in = 1'b0;

        fork
            forever begin @(negedge clk); mon_step(); end
            forever begin @(posedge clk); #1 rdy_step(); end
        join_none

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_vlds", 64'({bus.Q_vld_out, bus.K_vld_out, bus.V_vld_out}), 64'(0));
        chk("rst_rens", 64'({bus.q_mem_ren, bus.k_mem_ren, bus.v_mem_ren}), 64'(0));
        chk("rst_addrs", 64'({bus.q_mem_addr, bus.k_mem_addr, bus.v_mem_addr}), 64'(0));
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 5; i++) run_job(tbl[i]);

        // Reset mid-job with a K read in flight across the reset edge.
        sb_clear();
        mode = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        cyc = 0;
        @(negedge clk);
        while (!bus.k_mem_ren && cyc < 20) begin @(negedge clk); cyc++; end
        chk("mid_ren_seen", 64'(bus.k_mem_ren), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_vlds", 64'({bus.Q_vld_out, bus.K_vld_out, bus.V_vld_out}), 64'(0));
        chk("mid_rst_rens", 64'({bus.q_mem_ren, bus.k_mem_ren, bus.v_mem_ren}), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("stale_not_pushed", 64'({bus.Q_vld_out, bus.K_vld_out, bus.V_vld_out}), 64'(0));
        chk("idle_after_rst", 64'(busy), 64'(0));
        run_job(tbl[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
